axis_frame_gen: RTL and testbench

AXIS_FRAME_GEN -- requirements
Module: axis_frame_gen

---
 rtl/axis_frame_gen_if.sv | 16 +
 rtl/axis_frame_gen.sv | 196 +++++++++++++++++++
 tb/tb_axis_frame_gen.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_frame_gen_if.sv
// AXI4-Stream bundle carrying the generator's output beats.
// Master drives the beat fields; slave returns tready.
interface axis_frame_gen_if #(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic                  tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_frame_gen.sv
// Programmable AXI4-Stream frame generator: emits a run of fixed-length frames with
// incrementing data, optional inter-frame gaps, periodic bad-frame marking and a stop request.
module axis_frame_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start,
    input  logic                  cfg_stop,
    input  logic [LEN_WIDTH-1:0]  cfg_frame_len,
    input  logic [LEN_WIDTH-1:0]  cfg_frame_count,
    input  logic [7:0]            cfg_gap,
    input  logic [DATA_WIDTH-1:0] cfg_seed,
    input  logic [7:0]            cfg_bad_every,
    axis_frame_gen_if.master      m_axis,
    output logic                  status_busy,
    output logic                  status_done,
    output logic [LEN_WIDTH-1:0]  status_frames_sent,
    output logic [31:0]           status_beats_sent
);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = 1;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d, count_q, count_d;
    logic [7:0]            gap_q, gap_d, bad_q, bad_d;
    logic [DATA_WIDTH-1:0] seed_q, seed_d;
    logic [LEN_WIDTH-1:0]  beat_q, beat_d, frames_q, frames_d;
    logic [31:0]           beats_q, beats_d;
    logic [7:0]            gap_cnt_q, gap_cnt_d, bad_cnt_q, bad_cnt_d;
    logic                  stop_q, stop_d, busy_q, busy_d, done_q, done_d;
    logic                  tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [KEEP_WIDTH-1:0] tkeep_q, tkeep_d;

    // bad_cnt tracks the frame index modulo the bad-frame period.
    function automatic logic frame_bad(input logic [7:0] every, input logic [7:0] idx);
        return (every != 8'd0) && (idx == every - 8'd1);
    endfunction

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        count_d   = count_q;
        gap_d     = gap_q;
        bad_d     = bad_q;
        seed_d    = seed_q;
        beat_d    = beat_q;
        frames_d  = frames_q;
        beats_d   = beats_q;
        gap_cnt_d = gap_cnt_q;
        bad_cnt_d = bad_cnt_q;
        stop_d    = stop_q;
        done_d    = 1'b0;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        tuser_d   = tuser_q;
        tdata_d   = tdata_q;
        tkeep_d   = tkeep_q;
        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    if (cfg_frame_len != '0 && cfg_frame_count != '0) begin
                        len_d     = cfg_frame_len;
                        count_d   = cfg_frame_count;
                        gap_d     = cfg_gap;
                        bad_d     = cfg_bad_every;
                        seed_d    = cfg_seed;
                        beat_d    = '0;
                        frames_d  = '0;
                        beats_d   = '0;
                        gap_cnt_d = '0;
                        bad_cnt_d = '0;
                        stop_d    = 1'b0;
                        state_d   = SEND;
                        tvalid_d  = 1'b1;
                        tdata_d   = cfg_seed;
                        tkeep_d   = '1;
                        tlast_d   = (cfg_frame_len == LEN_ONE);
                        tuser_d   = tlast_d && frame_bad(cfg_bad_every, 8'd0);
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (cfg_stop) stop_d = 1'b1;
                if (tvalid_q && m_axis.tready) begin
                    beats_d = beats_q + 32'd1;
                    if (tlast_q) begin
                        frames_d  = frames_q + LEN_ONE;
                        beat_d    = '0;
                        bad_cnt_d = (bad_cnt_q == bad_q - 8'd1) ? 8'd0 : bad_cnt_q + 8'd1;
                        if (frames_d == count_q || stop_q || cfg_stop) begin
                            state_d  = IDLE;
                            tvalid_d = 1'b0;
                            tlast_d  = 1'b0;
                            tuser_d  = 1'b0;
                            done_d   = 1'b1;
                        end else if (gap_q == 8'd0) begin
                            tdata_d = seed_q;
                            tlast_d = (len_q == LEN_ONE);
                            tuser_d = tlast_d && frame_bad(bad_q, bad_cnt_d);
                        end else begin
                            state_d   = GAP;
                            gap_cnt_d = '0;
                            tvalid_d  = 1'b0;
                            tlast_d   = 1'b0;
                            tuser_d   = 1'b0;
                        end
                    end else begin
                        beat_d  = beat_q + LEN_ONE;
                        tdata_d = seed_q + DATA_WIDTH'(beat_d);
                        tlast_d = (beat_d == len_q - LEN_ONE);
                        tuser_d = tlast_d && frame_bad(bad_q, bad_cnt_q);
                    end
                end
            end
            GAP: begin
                if (cfg_stop || stop_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (gap_cnt_q == gap_q - 8'd1) begin
                    state_d  = SEND;
                    tvalid_d = 1'b1;
                    tdata_d  = seed_q;
                    tlast_d  = (len_q == LEN_ONE);
                    tuser_d  = tlast_d && frame_bad(bad_q, bad_cnt_q);
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            count_q   <= '0;
            gap_q     <= '0;
            bad_q     <= '0;
            seed_q    <= '0;
            beat_q    <= '0;
            frames_q  <= '0;
            beats_q   <= '0;
            gap_cnt_q <= '0;
            bad_cnt_q <= '0;
            stop_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            tuser_q   <= 1'b0;
            tdata_q   <= '0;
            tkeep_q   <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            count_q   <= count_d;
            gap_q     <= gap_d;
            bad_q     <= bad_d;
            seed_q    <= seed_d;
            beat_q    <= beat_d;
            frames_q  <= frames_d;
            beats_q   <= beats_d;
            gap_cnt_q <= gap_cnt_d;
            bad_cnt_q <= bad_cnt_d;
            stop_q    <= stop_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            tuser_q   <= tuser_d;
            tdata_q   <= tdata_d;
            tkeep_q   <= tkeep_d;
        end
    end

    assign m_axis.tvalid      = tvalid_q;
    assign m_axis.tdata       = tdata_q;
    assign m_axis.tkeep       = tkeep_q;
    assign m_axis.tlast       = tlast_q;
    assign m_axis.tuser       = tuser_q;
    assign status_busy        = busy_q;
    assign status_done        = done_q;
    assign status_frames_sent = frames_q;
    assign status_beats_sent  = beats_q;

endmodule

// File: tb/tb_axis_frame_gen.sv
// Scoreboard bench for axis_frame_gen: expected beats come from a frame-level model,
// a negedge monitor pops and compares every accepted beat.
module tb_axis_frame_gen;
    localparam int DW = 8;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_start, cfg_stop;
    logic [LW-1:0] cfg_frame_len, cfg_frame_count;
    logic [7:0]    cfg_gap, cfg_seed, cfg_bad_every;
    logic          status_busy, status_done;
    logic [LW-1:0] status_frames_sent;
    logic [31:0]   status_beats_sent;

    axis_frame_gen_if #(.DATA_WIDTH(DW)) axis ();

    axis_frame_gen #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst),
        .cfg_start(cfg_start), .cfg_stop(cfg_stop),
        .cfg_frame_len(cfg_frame_len), .cfg_frame_count(cfg_frame_count),
        .cfg_gap(cfg_gap), .cfg_seed(cfg_seed), .cfg_bad_every(cfg_bad_every),
        .m_axis(axis),
        .status_busy(status_busy), .status_done(status_done),
        .status_frames_sent(status_frames_sent), .status_beats_sent(status_beats_sent)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       l;
        logic       u;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;
    int    checks = 0;
    int    errors = 0;
    int    acc_beats = 0;
    int    ready_mode = 0;
    int    cur_gap = 0;
    bit    prev_stall = 0;
    logic [7:0] prev_d;
    logic  prev_l, prev_u;
    bit    in_gap = 0;
    int    gap_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: frame f beat b carries seed+b; last beat of every bad_every-th frame is bad.
    task automatic push_model(input int len, input int nframes, input int seed, input int bad);
        beat_t b;
        for (int f = 0; f < nframes; f++) begin
            for (int i = 0; i < len; i++) begin
                b.d = 8'((seed + i) % 256);
                b.l = (i == len - 1);
                b.u = (i == len - 1) && (bad != 0) && (((f + 1) % bad) == 0);
                exp_q.push_back(b);
            end
        end
    endtask

    initial begin
        axis.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       axis.tready = 1'b1;
                1:       axis.tready = ~axis.tready;
                default: axis.tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
            in_gap = 0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(axis.tvalid), 64'd1);
                check("hold_data", 64'(axis.tdata), 64'(prev_d));
                check("hold_last", 64'(axis.tlast), 64'(prev_l));
                check("hold_user", 64'(axis.tuser), 64'(prev_u));
            end
            if (status_done) in_gap = 0;
            if (axis.tvalid) begin
                if (in_gap) begin
                    check("gap_len", 64'(gap_seen), 64'(cur_gap));
                    in_gap = 0;
                end
                if (axis.tready) begin
                    acc_beats++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got data %0h, expected no beat", axis.tdata);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("beat_data", 64'(axis.tdata), 64'(mon_e.d));
                        check("beat_last", 64'(axis.tlast), 64'(mon_e.l));
                        check("beat_user", 64'(axis.tuser), 64'(mon_e.u));
                        check("beat_keep", 64'(axis.tkeep), 64'd1);
                    end
                    if (axis.tlast) begin
                        in_gap = 1;
                        gap_seen = 0;
                    end
                end
            end else if (in_gap) begin
                gap_seen++;
            end
            prev_stall = axis.tvalid && !axis.tready;
            prev_d = axis.tdata;
            prev_l = axis.tlast;
            prev_u = axis.tuser;
        end
    end

    task automatic run(input string tag, input int len, input int count, input int gap,
                       input int seed, input int bad, input int mode,
                       input int stop_at, input int nframes);
        int  base;
        bit  stop_sent;
        bit  got_done;
        stop_sent = 0;
        got_done = 0;
        ready_mode = mode;
        cur_gap = gap;
        push_model(len, nframes, seed, bad);
        base = acc_beats;
        cfg_frame_len = LW'(len);
        cfg_frame_count = LW'(count);
        cfg_gap = 8'(gap);
        cfg_seed = 8'(seed);
        cfg_bad_every = 8'(bad);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        check({tag, "_start_valid"}, 64'(axis.tvalid), 64'd1);
        check({tag, "_start_busy"}, 64'(status_busy), 64'd1);
        cfg_frame_len = LW'($urandom_range(0, 9));
        cfg_frame_count = LW'($urandom_range(0, 9));
        cfg_gap = 8'($urandom_range(0, 9));
        cfg_seed = 8'($urandom);
        cfg_bad_every = 8'($urandom_range(0, 5));
        for (int i = 0; i < 4000 && !got_done; i++) begin
            if (i == 3) cfg_start = 1'b1;
            if (stop_at > 0 && !stop_sent && (acc_beats - base) >= stop_at) begin
                cfg_stop = 1'b1;
                stop_sent = 1;
            end
            tick();
            cfg_start = 1'b0;
            cfg_stop = 1'b0;
            if (status_done) got_done = 1;
        end
        if (!got_done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done pulse, expected one within 4000 cycles", tag);
        end
        check({tag, "_frames"}, 64'(status_frames_sent), 64'(nframes));
        check({tag, "_beats"}, 64'(status_beats_sent), 64'(nframes * len));
        check({tag, "_idle_busy"}, 64'(status_busy), 64'd0);
        check({tag, "_idle_valid"}, 64'(axis.tvalid), 64'd0);
        check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
        tick();
        check({tag, "_done_width"}, 64'(status_done), 64'd0);
        check({tag, "_frames_hold"}, 64'(status_frames_sent), 64'(nframes));
        exp_q.delete();
    endtask

    task automatic zero_start(input string tag, input int len, input int count,
                              input int frames_prev, input int beats_prev);
        cfg_frame_len = LW'(len);
        cfg_frame_count = LW'(count);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        check({tag, "_done"}, 64'(status_done), 64'd1);
        check({tag, "_valid"}, 64'(axis.tvalid), 64'd0);
        check({tag, "_busy"}, 64'(status_busy), 64'd0);
        tick();
        check({tag, "_done_width"}, 64'(status_done), 64'd0);
        check({tag, "_valid2"}, 64'(axis.tvalid), 64'd0);
        check({tag, "_frames_hold"}, 64'(status_frames_sent), 64'(frames_prev));
        check({tag, "_beats_hold"}, 64'(status_beats_sent), 64'(beats_prev));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, 64'(axis.tvalid), 64'd0);
        check({tag, "_last"}, 64'(axis.tlast), 64'd0);
        check({tag, "_user"}, 64'(axis.tuser), 64'd0);
        check({tag, "_data"}, 64'(axis.tdata), 64'd0);
        check({tag, "_keep"}, 64'(axis.tkeep), 64'd0);
        check({tag, "_busy"}, 64'(status_busy), 64'd0);
        check({tag, "_done"}, 64'(status_done), 64'd0);
        check({tag, "_frames"}, 64'(status_frames_sent), 64'd0);
        check({tag, "_beats"}, 64'(status_beats_sent), 64'd0);
    endtask

    initial begin
        int len, count, gap, bad, k, nfr, stop_at;
        rst = 1'b1;
        cfg_start = 1'b0;
        cfg_stop = 1'b0;
        cfg_frame_len = '0;
        cfg_frame_count = '0;
        cfg_gap = '0;
        cfg_seed = '0;
        cfg_bad_every = '0;
        repeat (3) tick();
        check_reset_state("reset");
        rst = 1'b0;
        tick();

        run("basic", 4, 2, 0, 8'h10, 0, 0, 0, 2);
        run("stall_gap", 3, 2, 2, 8'h21, 0, 1, 0, 2);
        run("len1_bad", 1, 4, 0, 8'h05, 2, 0, 0, 4);
        run("wrap", 4, 1, 0, 8'hFE, 0, 0, 0, 1);
        zero_start("zero_len", 0, 3, 1, 4);
        zero_start("zero_cnt", 5, 0, 1, 4);
        run("stop_send", 4, 10, 0, 8'h30, 3, 0, 9, 3);
        run("stop_gap", 2, 5, 5, 8'h44, 0, 0, 2, 1);

        for (int r = 0; r < 30; r++) begin
            len = $urandom_range(1, 6);
            count = $urandom_range(1, 5);
            gap = $urandom_range(0, 3);
            bad = $urandom_range(0, 4);
            stop_at = 0;
            nfr = count;
            if ($urandom_range(0, 3) == 0) begin
                cfg_stop = 1'b1;
                tick();
                cfg_stop = 1'b0;
            end
            if ($urandom_range(0, 2) == 0) begin
                if (len < 3) len = 3;
                k = $urandom_range(0, count - 1);
                stop_at = k * len + 1;
                nfr = k + 1;
            end
            run("rand", len, count, gap, $urandom_range(0, 255), bad,
                $urandom_range(0, 2), stop_at, nfr);
        end

        ready_mode = 0;
        push_model(8, 3, 8'h40, 0);
        cfg_frame_len = LW'(8);
        cfg_frame_count = LW'(3);
        cfg_gap = 8'd0;
        cfg_seed = 8'h40;
        cfg_bad_every = 8'd0;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check_reset_state("midrst");
        tick();
        check("midrst_stays_idle", 64'(axis.tvalid), 64'd0);

        cfg_frame_len = LW'(4);
        cfg_frame_count = LW'(2);
        rst = 1'b1;
        cfg_start = 1'b1;
        tick();
        rst = 1'b0;
        cfg_start = 1'b0;
        check_reset_state("rst_vs_start");
        tick();
        check("rst_vs_start_idle", 64'(axis.tvalid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
